// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Request-capture stage in front of the 8:3 priority encoder. Request
//   events are latched into sticky pending bits. The highest pending bit
//   (bit N-1 highest, bit 0 lowest) is granted through a valid/ack handshake.
//   The granted bit is cleared when the consumer acknowledges it.
//
//   Build option:
//     IRQ_EDGE_EN - when defined, an event is a rising edge of req[i],
//                   detected against a registered copy of req.
//                   When undefined, an event is req[i]==1 at the sampling
//                   edge, so the request is level-sensitive.
//
//   Ports:
//     clk      system clock, rising edge
//     rst      asynchronous active-high reset
//     req      request lines, bit i -> index i
//     ack      consumer acknowledge, only honoured while valid=1
//     ovf_clr  synchronous clear of ovf
//     valid    idx holds a granted request
//     idx      index of the granted request
//     pend     current pending register
//     ovf      sticky: an event hit a bit that was already pending

// One pending lane: event detection, sticky bit, overflow hit.
module irq_pend_cell (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,   // serviced this edge
    output logic pend,
    output logic hit    // event on an already-pending, not-cleared bit
);
    logic ev;

`ifdef IRQ_EDGE_EN
    logic req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= 1'b0;
        else     req_q <= req;
    end

    assign ev = req & ~req_q;
`else
    assign ev = req;
`endif

    // A set takes priority over the clear, so an event that coincides
    // with its own acknowledge is not lost. That case is not an overflow.
    assign hit = ev & pend & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= 1'b0;
        else     pend <= ev | (pend & ~clr);
    end
endmodule

module irq_pending_ctrl #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          ack,
    input  logic          ovf_clr,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  pend,
    output logic          ovf
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state;
    logic [N-1:0]  clr;
    logic [N-1:0]  hit;
    logic [IW-1:0] top_idx;

    for (genvar i = 0; i < N; i++) begin : g_lane
        irq_pend_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .req  (req[i]),
            .clr  (clr[i]),
            .pend (pend[i]),
            .hit  (hit[i])
        );
    end

    // Only the granted bit is cleared, and only on an acknowledged grant.
    always_comb begin
        clr = '0;
        if (state == GRANT && ack) clr[idx] = 1'b1;
    end

    // Highest set bit of the registered pend. This cycle's new events
    // are not visible until the next edge.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++)
            if (pend[i]) top_idx = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            // A new overflow beats a simultaneous clear.
            if (|hit)        ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;

            case (state)
                IDLE: if (|pend) begin
                    idx   <= top_idx;
                    valid <= 1'b1;
                    state <= GRANT;
                end
                // idx is frozen for the whole grant; there is no pre-emption.
                GRANT: if (ack) begin
                    valid <= 1'b0;
                    state <= GAP;
                end
                // One forced idle cycle, so valid always drops between grants.
                GAP: state <= IDLE;
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Sequential request-capture stage that sits directly upstream of the 8:3 priority encoder.
- Latches eight asynchronous-in-time request lines into sticky pending bits, then selects the highest-priority pending bit and presents its 3-bit index with a valid/ack handshake.
- Clears each serviced bit on acknowledge.
- Priority order matches the encoder: bit 7 highest, bit 0 lowest.

Parameters:
- N, 8, number of request lines.
- IW, 3, index width; must equal clog2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request lines; bit i corresponds to encoder input a(i+1).
- ack  input  1  consumer acknowledge; meaningful only while valid=1.
- ovf_clr  input  1  synchronous clear of ovf.
- valid  output  1  idx holds a granted request.
- idx  output  IW  index of granted request; bit 7 -> 3'b111 ... bit 0 -> 3'b000.
- pend  output  N  current pending register.
- ovf  output  1  sticky: a new request arrived on an already-pending bit.

Behaviour:
- Reset (async, rst=1):
  - pend=0, valid=0, idx=0, ovf=0, FSM=IDLE.
  - Edge-history register = 0.
  - Takes effect immediately, mid-handshake included; the in-flight grant is discarded.
- Request event: per bit, defined by IRQ_EDGE_EN (see Optional Feature). An event on bit i sets pend[i] at the next edge.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - valid=0.
  - If pend != 0: capture idx = index of highest set bit of pend (registered value, not including this cycle's new events), go to GRANT.
  - Latency: event at edge k -> pend at k+1 -> valid=1 at k+2.
- GRANT:
  - valid=1; idx held stable regardless of new higher-priority events (no pre-emption).
  - On ack=1 at an edge: clear pend[idx], go to GAP.
  - ack=0: remain.
- GAP: valid=0 for exactly one cycle, then IDLE. This guarantees valid deasserts between consecutive grants.
- ack while valid=0: ignored, no state change.
- Simultaneous event on bit idx and ack clearing it, same edge: set wins; pend[idx] stays 1 so no event is lost. ovf is not set in this case.
- Overflow:
  - An event on bit i while pend[i]=1 (and not being cleared that edge) sets ovf=1.
  - ovf holds until ovf_clr=1 at an edge.
  - If a new overflow and ovf_clr occur at the same edge, the new overflow wins and ovf stays 1.
- Multiple events on different bits in one cycle: all captured.
- No width growth: idx is IW bits; all-zero pend never produces valid.

Optional Feature:
- Macro: IRQ_EDGE_EN.
- Defined:
  - Event = rising edge of req[i], detected against a registered copy of req (reset 0).
  - A level held high generates a single event.
- Undefined:
  - Event = req[i]==1 at the sampling edge (level-sensitive).
  - Held-high req re-sets pend[i] after each service, and sets ovf every cycle while pend[i]=1.
  - The edge-history register is not instantiated.

Test Plan:
- Reset then req=8'b0000_0100 one-cycle pulse -> pend=8'h04 after 1 edge; valid=1, idx=3'b010 one edge later; ack=1 -> pend=8'h00, valid=0.
- req=8'b0101_0000 pulse -> idx=3'b110 granted first. After ack -> GAP cycle valid=0, then idx=3'b100 granted; after second ack pend=0.
- While granting idx=3'b001, pulse req[7] -> idx stays 3'b001 until ack; next grant idx=3'b111.
- Pulse req[2] twice before service -> ovf=1; ovf_clr=1 -> ovf=0. Pulse req[2] on the same edge as ack of idx=3'b010 -> pend[2] remains 1, second grant idx=3'b010, ovf stays 0.
- Assert rst asynchronously mid-GRANT with pend=8'hFF -> valid, idx, pend, ovf all 0 immediately without a clock edge. After release, no grant until a new event.
- Hold req[5]=1 for 10 cycles, acking each grant:
  - With IRQ_EDGE_EN: exactly one grant idx=3'b101.
  - Without IRQ_EDGE_EN: repeated grants idx=3'b101 and ovf=1.
